// File: rtl/cram16x4_cfg_seq.sv
// Config sequencer for one 16x4 cram tile: turns row commands into timed bitline/wordline pulses.
// Latency: write row 1+SETUP+WL+HOLD cycles accept->ready, readback 1+SETUP+WL cycles accept->rd_valid.
// Backpressure: cmd_ready only in IDLE (no queueing); burst stalls in BWAIT until bw_valid.
module cram16x4_cfg_seq #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned WL_CYC    = 4,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned CLR_CYC   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_row,
    input  logic [3:0]  cmd_data,
    input  logic        bw_valid,
    output logic        bw_ready,
    input  logic [3:0]  bw_data,
    output logic [15:0] wl,
    output logic [3:0]  bl_out,
    output logic        bl_oe,
    input  logic [3:0]  bl_in,
    output logic [15:0] pgate,
    output logic [15:0] reset_b,
    output logic [15:0] vdd_cntl,
    output logic        prog,
    output logic        rd_valid,
    output logic [3:0]  rd_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SETUP, S_PULSE, S_HOLD, S_BWAIT, S_RSENSE
    } state_t;

    // Phase counter is loaded with (duration-1) and the state exits when it reaches zero.
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] WL_LD    = 4'(WL_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
    localparam logic [3:0] CLR_LD   = 4'(CLR_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  data_q, data_d;
    logic        rd_op_q, rd_op_d;
    logic        burst_q, burst_d;
    logic [3:0]  rd_data_q, rd_data_d;

    logic [15:0] wl_q, wl_d;
    logic [15:0] pgate_q, pgate_d;
    logic [15:0] reset_b_q, reset_b_d;
    logic [15:0] vdd_cntl_q;
    logic [3:0]  bl_out_q, bl_out_d;
    logic        bl_oe_q, bl_oe_d;
    logic        prog_q, rd_valid_q, cmd_ready_q, bw_ready_q, busy_q;
    logic        drive_d;
    logic [15:0] row_oh_d;

    // Next-state sequencing: command decode, phase timing and burst row stepping.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        row_d     = row_q;
        data_d    = data_q;
        rd_op_d   = rd_op_q;
        burst_d   = burst_q;
        rd_data_d = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rd_op_d = 1'b0;
                    burst_d = 1'b0;
                    case (cmd_op)
                        2'b00: begin
                            state_d = S_CLR;
                            phase_d = CLR_LD;
                        end
                        2'b01: begin
                            state_d = S_SETUP;
                            phase_d = SETUP_LD;
                            row_d   = cmd_row;
                            data_d  = cmd_data;
                        end
                        2'b10: begin
                            state_d = S_BWAIT;
                            row_d   = 4'd0;
                            data_d  = 4'd0;
                            burst_d = 1'b1;
                        end
                        default: begin
                            state_d = S_SETUP;
                            phase_d = SETUP_LD;
                            row_d   = cmd_row;
                            data_d  = 4'd0;
                            rd_op_d = 1'b1;
                        end
                    endcase
                end
            end
            S_CLR: begin
                if (phase_q == 4'd0) state_d = S_IDLE;
                else                 phase_d = phase_q - 4'd1;
            end
            S_SETUP: begin
                if (phase_q == 4'd0) begin
                    state_d = S_PULSE;
                    phase_d = WL_LD;
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            S_PULSE: begin
                if (phase_q == 4'd0) begin
                    if (rd_op_q) begin
                        state_d   = S_RSENSE;
                        rd_data_d = bl_in;
                    end else begin
                        state_d = S_HOLD;
                        phase_d = HOLD_LD;
                    end
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (phase_q == 4'd0) begin
                    if (burst_q && row_q != 4'd15) begin
                        state_d = S_BWAIT;
                        row_d   = row_q + 4'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            S_BWAIT: begin
                if (bw_valid) begin
                    state_d = S_SETUP;
                    phase_d = SETUP_LD;
                    data_d  = bw_data;
                end
            end
            S_RSENSE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every pin comes straight off a flop.
    always_comb begin
        row_oh_d  = 16'd1 << row_d;
        drive_d   = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_HOLD);
        wl_d      = (state_d == S_PULSE) ? row_oh_d : 16'd0;
        pgate_d   = drive_d ? row_oh_d : 16'd0;
        reset_b_d = (state_d == S_CLR) ? 16'h0000 : 16'hFFFF;
        bl_oe_d   = drive_d && !rd_op_d;
        bl_out_d  = bl_oe_d ? data_d : 4'd0;
    end

    // State and registered outputs; reset forces the safe idle pattern at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= 4'd0;
            row_q       <= 4'd0;
            data_q      <= 4'd0;
            rd_op_q     <= 1'b0;
            burst_q     <= 1'b0;
            rd_data_q   <= 4'd0;
            wl_q        <= 16'd0;
            pgate_q     <= 16'd0;
            reset_b_q   <= 16'hFFFF;
            vdd_cntl_q  <= 16'd0;
            bl_out_q    <= 4'd0;
            bl_oe_q     <= 1'b0;
            prog_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            bw_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            row_q       <= row_d;
            data_q      <= data_d;
            rd_op_q     <= rd_op_d;
            burst_q     <= burst_d;
            rd_data_q   <= rd_data_d;
            wl_q        <= wl_d;
            pgate_q     <= pgate_d;
            reset_b_q   <= reset_b_d;
            vdd_cntl_q  <= 16'd0;
            bl_out_q    <= bl_out_d;
            bl_oe_q     <= bl_oe_d;
            prog_q      <= (state_d != S_IDLE);
            rd_valid_q  <= (state_d == S_RSENSE);
            cmd_ready_q <= (state_d == S_IDLE);
            bw_ready_q  <= (state_d == S_BWAIT);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign wl        = wl_q;
    assign pgate     = pgate_q;
    assign reset_b   = reset_b_q;
    assign vdd_cntl  = vdd_cntl_q;
    assign bl_out    = bl_out_q;
    assign bl_oe     = bl_oe_q;
    assign prog      = prog_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign cmd_ready = cmd_ready_q;
    assign bw_ready  = bw_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cram16x4_cfg_seq.sv
// Bench for cram16x4_cfg_seq at default timing parameters.
// Readback data and burst wordlines are tracked through expectation queues.
// Per-cycle monitor checks the wordline/clear/pgate invariants.
module tb_cram16x4_cfg_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [3:0]  cmd_row = 4'd0;
    logic [3:0]  cmd_data = 4'd0;
    logic        bw_valid = 1'b0;
    logic        bw_ready;
    logic [3:0]  bw_data = 4'd0;
    logic [15:0] wl;
    logic [3:0]  bl_out;
    logic        bl_oe;
    logic [3:0]  bl_in = 4'd0;
    logic [15:0] pgate;
    logic [15:0] reset_b;
    logic [15:0] vdd_cntl;
    logic        prog;
    logic        rd_valid;
    logic [3:0]  rd_data;
    logic        busy;

    cram16x4_cfg_seq dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_data(cmd_data),
        .bw_valid(bw_valid), .bw_ready(bw_ready), .bw_data(bw_data),
        .wl(wl), .bl_out(bl_out), .bl_oe(bl_oe), .bl_in(bl_in),
        .pgate(pgate), .reset_b(reset_b), .vdd_cntl(vdd_cntl), .prog(prog),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] data;
        int         cyc;
    } rd_exp_t;
    rd_exp_t rd_q[$];

    typedef struct {
        logic [1:0] op;
        logic [3:0] row;
        logic [3:0] data;
        logic [3:0] blin;
        int         inj;
        int         e_ready;
        int         e_pg;
        int         e_wl_first;
        int         e_wl_last;
        int         e_clr;
        int         e_oe;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Readback scoreboard: each rd_valid must match the oldest expected value and cycle.
    always @(negedge clk) begin
        if (!reset && rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected actual=%0h required=none", rd_data);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk("rd_data", int'(rd_data), int'(e.data));
                chk("rd_cycle", cyc, e.cyc);
            end
        end
    end

    // Structural invariants checked every cycle.
    always @(negedge clk) begin
        checks++;
        if (((wl & (wl - 16'd1)) != 16'd0) || ((wl & ~pgate) != 16'd0) ||
            (wl != 16'd0 && reset_b != 16'hFFFF) || vdd_cntl != 16'd0) begin
            failures++;
            $display("FAIL invariant wl=%h pgate=%h reset_b=%h vdd_cntl=%h", wl, pgate, reset_b, vdd_cntl);
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        logic [15:0] oh;
        int first_wl, last_wl, pg_n, pg_bad, clr_n, oe_n, blo_bad, prog_n, wl_bad, ready_c;
        oh = 16'd1 << v.row;
        first_wl = 0; last_wl = 0; pg_n = 0; pg_bad = 0; clr_n = 0; oe_n = 0;
        blo_bad = 0; prog_n = 0; wl_bad = 0; ready_c = 0;
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_row   = v.row;
        cmd_data  = v.data;
        bl_in     = v.blin;
        if (v.op == 2'b11) rd_q.push_back('{v.blin, cyc + 7});
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            cmd_valid = (c == v.inj);
            cmd_op    = 2'b00;
            if (pgate == oh) pg_n++;
            else if (pgate != 16'd0) pg_bad++;
            if (wl == oh && v.op != 2'b00) begin
                if (first_wl == 0) first_wl = c;
                last_wl = c;
            end else if (wl != 16'd0) begin
                wl_bad++;
            end
            if (reset_b == 16'h0000) clr_n++;
            if (bl_oe) begin
                oe_n++;
                if (bl_out != v.data) blo_bad++;
            end
            if (prog && busy) prog_n++;
            if (cmd_ready) begin
                ready_c = c;
                break;
            end
        end
        cmd_valid = 1'b0;
        chk($sformatf("v%0d_ready_cyc", idx), ready_c, v.e_ready);
        chk($sformatf("v%0d_pgate_cyc", idx), pg_n, v.e_pg);
        chk($sformatf("v%0d_pgate_bad", idx), pg_bad, 0);
        chk($sformatf("v%0d_wl_first", idx), first_wl, v.e_wl_first);
        chk($sformatf("v%0d_wl_last", idx), last_wl, v.e_wl_last);
        chk($sformatf("v%0d_wl_bad", idx), wl_bad, 0);
        chk($sformatf("v%0d_clr_cyc", idx), clr_n, v.e_clr);
        chk($sformatf("v%0d_oe_cyc", idx), oe_n, v.e_oe);
        chk($sformatf("v%0d_bl_out_bad", idx), blo_bad, 0);
        chk($sformatf("v%0d_prog_cyc", idx), prog_n, v.e_ready - 1);
    endtask

    task automatic run_burst();
        int r, stall, stall_bad, hs, pulses, done;
        logic [15:0] prev;
        int rq[$];
        r = 0; stall = 0; stall_bad = 0; hs = 0; pulses = 0; done = 0; prev = 16'd0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (wl != 16'd0 && prev == 16'd0) begin
                pulses++;
                if (rq.size() == 0) begin
                    chk("burst_extra_pulse", int'(wl), 0);
                end else begin
                    int er;
                    er = rq.pop_front();
                    chk("burst_wl", int'(wl), int'(16'd1 << er));
                    chk("burst_bl_out", int'(bl_out), er);
                end
            end
            prev = wl;
            if (cmd_ready) begin
                done = 1;
                break;
            end
            if (bw_ready && r == 7 && stall < 3) begin
                bw_valid = 1'b0;
                stall++;
                if (!prog) stall_bad++;
            end else begin
                bw_valid = bw_ready && (r < 16);
                bw_data  = 4'(r);
            end
            if (bw_valid && bw_ready) begin
                hs++;
                rq.push_back(r);
                r++;
            end
            @(posedge clk); #1;
        end
        bw_valid = 1'b0;
        chk("burst_done", done, 1);
        chk("burst_handshakes", hs, 16);
        chk("burst_pulses", pulses, 16);
        chk("burst_stall_cyc", stall, 3);
        chk("burst_stall_prog", stall_bad, 0);
        chk("burst_pending", rq.size(), 0);
        chk("burst_idle_bw_ready", int'(bw_ready), 0);
    endtask

    initial begin
        //            op     row    data   blin  inj rdy pg f  l  clr oe
        vecs[0] = '{2'b01, 4'd9,  4'hA, 4'h0, 0, 8, 7, 3, 6, 0, 7};
        vecs[1] = '{2'b11, 4'd3,  4'h0, 4'h6, 0, 8, 6, 3, 6, 0, 0};
        vecs[2] = '{2'b00, 4'd0,  4'h0, 4'h0, 0, 9, 0, 0, 0, 8, 0};
        vecs[3] = '{2'b01, 4'd0,  4'h5, 4'h0, 0, 8, 7, 3, 6, 0, 7};
        vecs[4] = '{2'b11, 4'd15, 4'h0, 4'h9, 0, 8, 6, 3, 6, 0, 0};
        vecs[5] = '{2'b01, 4'd15, 4'hF, 4'h0, 4, 8, 7, 3, 6, 0, 7};
        vecs[6] = '{2'b11, 4'd0,  4'h0, 4'h0, 0, 8, 6, 3, 6, 0, 0};
        vecs[7] = '{2'b00, 4'd7,  4'h0, 4'h0, 3, 9, 0, 0, 0, 8, 0};

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wl", int'(wl), 0);
        chk("rst_pgate", int'(pgate), 0);
        chk("rst_reset_b", int'(reset_b), 16'hFFFF);
        chk("rst_bl", int'({bl_oe, bl_out}), 0);
        chk("rst_prog_busy", int'({prog, busy, rd_valid, bw_ready}), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        run_burst();

        // Reset in the middle of a write pulse to row 5.
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_row   = 4'd5;
        cmd_data  = 4'h3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_pulse_wl", int'(wl), 16'h0020);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_wl", int'(wl), 0);
        chk("async_rst_pgate", int'(pgate), 0);
        chk("async_rst_reset_b", int'(reset_b), 16'hFFFF);
        chk("async_rst_bl_oe", int'(bl_oe), 0);
        chk("async_rst_prog", int'(prog), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("after_rst_ready", int'(cmd_ready), 1);
        chk("after_rst_busy", int'(busy), 0);
        chk("after_rst_wl", int'(wl), 0);

        repeat (2) @(posedge clk);
        chk("rd_scoreboard_empty", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cram16x4_cfg_seq.md
Name: cram16x4_cfg_seq

Overview:
Configuration sequencer for one 16-row x 4-bitline config SRAM tile (64 cbits) driving wl, bl, pgate, reset_b, vdd_cntl and prog.
Accepts row-level commands from the column configuration shifter and converts each into a timed bitline/wordline pulse sequence: clear, single-row write, 16-row burst write and single-row readback.
Sits between the chip config controller and each tile's cram array.

Parameters:
SETUP_CYC, 2, cycles bitlines/pgate are driven before the wordline rises (1..15)
WL_CYC, 4, cycles the wordline is held high (1..15)
HOLD_CYC, 1, cycles bitlines stay driven after the wordline falls (1..15)
CLR_CYC, 8, cycles reset_b is held low for a clear (1..15)

Ports:
clk  input  1  tile configuration clock
reset  input  1  asynchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_op  input  2  00 clear-all, 01 write row, 10 burst write, 11 readback row
cmd_row  input  4  target row (ignored for clear and burst)
cmd_data  input  4  write data for write row
bw_valid  input  1  burst data word valid
bw_ready  output  1  burst word accepted this cycle
bw_data  input  4  burst data; rows 0..15 taken in order
wl  output  16  one-hot wordline, active-high
bl_out  output  4  bitline drive value
bl_oe  output  1  bitline drive enable (the bidirectional pad lives in the tile wrapper)
bl_in  input  4  sensed bitline value
pgate  output  16  per-row write-gate enable, active-high
reset_b  output  16  per-row clear, active-low
vdd_cntl  output  16  per-row supply pFET gate, active-low (0 = supplied)
prog  output  1  programming mode, high while any command is in progress
rd_valid  output  1  single-cycle readback strobe
rd_data  output  4  readback data
busy  output  1  high outside IDLE

Behaviour:
- Clocking and reset: all state is on the clk rising edge. Reset is asynchronous and active-high.
- Reset values: state IDLE, wl=0, pgate=0, reset_b=16'hFFFF, vdd_cntl=0, bl_out=0, bl_oe=0, prog=0, rd_valid=0, rd_data=0, cmd_ready=1, bw_ready=0, busy=0.
- States: IDLE, CLR, SETUP, PULSE, HOLD, BWAIT, RSENSE. A 4-bit phase counter and a 4-bit row register are used.
- IDLE: a command is accepted when cmd_valid&&cmd_ready. prog rises in the following cycle.
  - op 00 -> CLR
  - op 01 -> SETUP; latch row and data
  - op 10 -> BWAIT; row=0
  - op 11 -> SETUP with bl_oe=0
- CLR: reset_b=0 on all rows for exactly CLR_CYC cycles, then IDLE. wl and pgate stay 0.
- SETUP: pgate[row]=1. bl_oe=1 and bl_out=data for writes. Lasts SETUP_CYC cycles, then PULSE.
- PULSE: wl[row]=1 for WL_CYC cycles.
  - Write: go to HOLD.
  - Readback: sample bl_in into rd_data on the last PULSE cycle. Go to RSENSE, which asserts rd_valid for exactly 1 cycle, then IDLE.
- HOLD: wl=0, bitlines still driven, HOLD_CYC cycles.
  - Write row: go to IDLE.
  - Burst: if row==15 go to IDLE; else row++ and go to BWAIT.
- BWAIT: bw_ready=1. On bw_valid, latch bw_data and go to SETUP. Stalls indefinitely without bw_valid, with prog held at 1.
- Write row latency: 1+SETUP_CYC+WL_CYC+HOLD_CYC cycles from accept to cmd_ready; 8 cycles at defaults.
- Readback latency: accept to rd_valid is 1+SETUP_CYC+WL_CYC cycles; 7 at defaults.
- Invariants:
  - wl is never active in the same cycle as any reset_b=0.
  - At most one wl bit is high.
  - wl is only high while pgate for the same row is high.
- vdd_cntl stays all-zero in every state. It is registered for future per-row power gating.
- cmd_valid outside IDLE is ignored. Commands are not queued.
- Burst row counter never wraps. Exactly 16 words are consumed per burst.
- Reset mid-operation forces the reset values immediately. A partially written row is not retried.

Test Plan:
- Reset: assert reset mid-PULSE of a write to row 5 -> wl and pgate go to 0 asynchronously; reset_b=FFFF; cmd_ready=1 after release.
- Clear: op 00 -> reset_b=0000 for exactly 8 cycles; wl=0 throughout; prog=1 for 8 cycles; then cmd_ready=1.
- Single write: op 01, row 9, data A ->
  - pgate=0200 for 7 cycles
  - wl=0200 for cycles 3-6
  - bl_out=A with bl_oe=1 over those cycles
  - cmd_ready returns on cycle 8
- Readback: op 11, row 3, with bl_in=6 -> bl_oe=0, wl=0008, rd_valid pulses 7 cycles after accept, rd_data=6.
- Burst with stalls: op 10, feed data 0..F, dropping bw_valid for 3 cycles before row 7 ->
  - wl one-hot sequence steps 0001..8000
  - prog stays 1 during the stall
  - exactly 16 bw_ready handshakes
  - IDLE after row 15
- Ignored command: pulse cmd_valid with op 00 during a write -> no CLR occurs; the write timing is unchanged.
